// File: rtl/ni_pkg.sv
// -----------------------------------------------------------------------------
// ni_pkg
// Shared definitions for the network-interface transmit path: flit type codes,
// flit/entry widths, entry field positions and the scheduler FSM encoding.
// -----------------------------------------------------------------------------
package ni_pkg;

  localparam int FLIT_W   = 34;
  localparam int ENTRY_W  = 64;
  localparam int DATA_MSB = 63;
  localparam int ADDR_MSB = 31;

  localparam logic [1:0] FLIT_IDLE = 2'b00;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;

  // Scheduler FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_HEAD = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  // Assemble a link flit from its type code and 32-bit payload
  function automatic logic [FLIT_W-1:0] make_flit(input logic [1:0]  flit_type,
                                                   input logic [31:0] payload);
    return {flit_type, payload};
  endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// -----------------------------------------------------------------------------
// ni_credit_counter
// Saturating credit counter for a credit-based link. Starts full (MAX) on
// reset, decrements on take, increments on give; take and give together leave
// the count unchanged. A give while already full is dropped and sets a sticky
// error flag that only reset clears.
//   clk, reset : clock, asynchronous active-high reset
//   take       : consume one credit (caller guarantees count > 0)
//   give       : one credit returned
//   count      : current credit count
//   empty      : count == 0
//   err        : sticky overflow (give while full)
// -----------------------------------------------------------------------------
module ni_credit_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         take,
  input  logic         give,
  output logic [W-1:0] count,
  output logic         empty,
  output logic         err
);

  localparam logic [W-1:0] MAX_C  = W'(MAX);
  localparam logic [W-1:0] ZERO_C = {W{1'b0}};
  localparam logic [W-1:0] ONE_C  = W'(1);

  logic [W-1:0] count_r;
  logic [W-1:0] count_next_s;
  logic         err_r;
  logic         err_next_s;

  // Next-count and overflow-flag computation
  always_comb begin
    count_next_s = count_r;
    err_next_s   = err_r;
    case ({take, give})
      2'b10: begin
        // Guard keeps the counter from wrapping even if a caller misbehaves
        if (count_r != ZERO_C) begin
          count_next_s = count_r - ONE_C;
        end else begin
          count_next_s = count_r;
        end
      end
      2'b01: begin
        if (count_r == MAX_C) begin
          err_next_s = 1'b1;
        end else begin
          count_next_s = count_r + ONE_C;
        end
      end
      default: begin
        count_next_s = count_r;
      end
    endcase
  end

  // Credit count and sticky error registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= MAX_C;
      err_r   <= 1'b0;
    end else begin
      count_r <= count_next_s;
      err_r   <= err_next_s;
    end
  end

  assign count = count_r;
  assign empty = (count_r == ZERO_C);
  assign err   = err_r;

endmodule

// File: rtl/ni_tx_scheduler.sv
// -----------------------------------------------------------------------------
// ni_tx_scheduler
// Pops 64-bit {data, addr} entries from the core-to-NoC write FIFO and sends
// each as a HEAD (addr) + TAIL (data) flit pair on the credit-controlled NoC
// injection link.
//   clk, reset   : clock, asynchronous active-high reset
//   en           : allow new packets to start (checked in IDLE only)
//   fifo_empty   : FIFO empty flag
//   fifo_data    : FIFO read data, valid the cycle after fifo_read_en
//   fifo_read_en : one-cycle pop strobe
//   flit_out     : {type[1:0], payload[31:0]}, registered
//   flit_valid   : registered flit strobe, one credit per flit
//   credit_in    : one pulse per freed downstream slot
//   credits      : current credit count
//   busy         : FSM not in IDLE
//   pkt_count    : completed packets, wraps modulo 2^16
//   credit_err   : sticky credit-overflow flag
// -----------------------------------------------------------------------------
module ni_tx_scheduler
  import ni_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               fifo_empty,
  input  logic [ENTRY_W-1:0] fifo_data,
  output logic               fifo_read_en,
  output logic [FLIT_W-1:0]  flit_out,
  output logic               flit_valid,
  input  logic               credit_in,
  output logic [CW-1:0]      credits,
  output logic               busy,
  output logic [15:0]        pkt_count,
  output logic               credit_err
);

  logic [1:0]         state_r;
  logic [1:0]         state_next_s;
  logic [ENTRY_W-1:0] hold_r;
  logic [FLIT_W-1:0]  flit_out_r;
  logic [FLIT_W-1:0]  flit_next_s;
  logic               flit_valid_r;
  logic               send_s;
  logic               pop_s;
  logic               tail_s;
  logic               busy_r;
  logic [15:0]        pkt_count_r;
  logic               credits_empty_s;

  ni_credit_counter #(
    .MAX (CREDITS),
    .W   (CW)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .take  (send_s),
    .give  (credit_in),
    .count (credits),
    .empty (credits_empty_s),
    .err   (credit_err)
  );

  // FSM next state and flit selection; the credit test uses the registered
  // count, so a credit arriving this cycle only helps on the next one
  always_comb begin
    state_next_s = state_r;
    send_s       = 1'b0;
    pop_s        = 1'b0;
    tail_s       = 1'b0;
    flit_next_s  = make_flit(FLIT_IDLE, 32'h0000_0000);
    case (state_r)
      ST_IDLE: begin
        if (en && !fifo_empty) begin
          pop_s        = 1'b1;
          state_next_s = ST_POP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_POP: begin
        state_next_s = ST_HEAD;
      end
      ST_HEAD: begin
        if (!credits_empty_s) begin
          send_s       = 1'b1;
          flit_next_s  = make_flit(FLIT_HEAD, hold_r[ADDR_MSB:0]);
          state_next_s = ST_TAIL;
        end else begin
          state_next_s = ST_HEAD;
        end
      end
      ST_TAIL: begin
        if (!credits_empty_s) begin
          send_s       = 1'b1;
          tail_s       = 1'b1;
          flit_next_s  = make_flit(FLIT_TAIL, hold_r[DATA_MSB:ADDR_MSB+1]);
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_TAIL;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, holding register, registered link outputs and packet counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      hold_r       <= {ENTRY_W{1'b0}};
      flit_out_r   <= {FLIT_W{1'b0}};
      flit_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      pkt_count_r  <= 16'h0000;
    end else begin
      state_r      <= state_next_s;
      flit_out_r   <= flit_next_s;
      flit_valid_r <= send_s;
      busy_r       <= (state_next_s != ST_IDLE);
      // Entry arrives the cycle after the pop strobe, i.e. while in POP
      if (state_r == ST_POP) begin
        hold_r <= fifo_data;
      end
      if (tail_s) begin
        pkt_count_r <= pkt_count_r + 16'h0001;
      end
    end
  end

  // The pop strobe is decoded straight from IDLE so the entry is on fifo_data
  // during POP; gating with reset keeps the FIFO untouched while in reset.
  assign fifo_read_en = pop_s && !reset;
  assign flit_out     = flit_out_r;
  assign flit_valid   = flit_valid_r;
  assign busy         = busy_r;
  assign pkt_count    = pkt_count_r;

endmodule

// File: tb/tb_ni_tx_scheduler.sv
module tb_ni_tx_scheduler;
  import ni_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        fifo_empty;
  logic [63:0] fifo_data;
  logic        fifo_read_en;
  logic [33:0] flit_out;
  logic        flit_valid;
  logic        credit_in;
  logic [2:0]  credits;
  logic        busy;
  logic [15:0] pkt_count;
  logic        credit_err;

  ni_tx_scheduler #(.CREDITS(4), .CW(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .flit_out     (flit_out),
    .flit_valid   (flit_valid),
    .credit_in    (credit_in),
    .credits      (credits),
    .busy         (busy),
    .pkt_count    (pkt_count),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        en;
    logic        fifo_empty;
    logic        credit_in;
    logic [63:0] fifo_data;
    logic        exp_rd;
    logic        exp_fv;
    logic [33:0] exp_flit;
    logic [2:0]  exp_cr;
    logic        exp_busy;
    logic [15:0] exp_pkt;
  } vec_t;

  vec_t vecs[9];

  // FIFO model and link observation for the hand-written sequences
  logic [63:0] q[$];
  int          rd_seen;
  int          flit_seen;
  logic [33:0] last_flit;
  logic        rd_now;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle starting at a falling edge: present FIFO state, observe
  // outputs, and deliver popped data after the rising edge
  task automatic cycle();
    fifo_empty = (q.size() == 0);
    #1;
    rd_now = fifo_read_en;
    if (fifo_read_en) rd_seen++;
    if (flit_valid) begin
      flit_seen++;
      last_flit = flit_out;
    end
    @(posedge clk);
    #1;
    if (rd_now && q.size() != 0) fifo_data = q.pop_front();
    credit_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    logic [63:0] e1;
    e1 = {32'hDEAD_BEEF, 32'h1000_0004};

    vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 34'h0,                          3'd4, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, e1,     1'b0, 1'b0, 34'h0,                          3'd4, 1'b1, 16'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, e1,     1'b0, 1'b0, 34'h0,                          3'd4, 1'b1, 16'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, e1,     1'b0, 1'b1, {FLIT_HEAD, 32'h1000_0004},     3'd3, 1'b1, 16'd0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, e1,     1'b0, 1'b1, {FLIT_TAIL, 32'hDEAD_BEEF},     3'd2, 1'b0, 16'd1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, e1,     1'b0, 1'b0, 34'h0,                          3'd2, 1'b0, 16'd1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, e1,     1'b0, 1'b0, 34'h0,                          3'd3, 1'b0, 16'd1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, e1,     1'b0, 1'b0, 34'h0,                          3'd4, 1'b0, 16'd1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, e1,     1'b0, 1'b0, 34'h0,                          3'd4, 1'b0, 16'd1};

    // Reset state
    reset = 1'b1; en = 1'b0; fifo_empty = 1'b1; credit_in = 1'b0; fifo_data = 64'h0;
    rd_seen = 0; flit_seen = 0; last_flit = 34'h0; rd_now = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rd",    {63'h0, fifo_read_en}, 64'd0);
    check("rst_fv",    {63'h0, flit_valid},   64'd0);
    check("rst_flit",  {30'h0, flit_out},     64'd0);
    check("rst_cr",    {61'h0, credits},      64'd4);
    check("rst_busy",  {63'h0, busy},         64'd0);
    check("rst_pkt",   {48'h0, pkt_count},    64'd0);
    check("rst_err",   {63'h0, credit_err},   64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single entry, cycle by cycle, followed by credit returns
    for (int i = 0; i < 9; i++) begin
      en = vecs[i].en; fifo_empty = vecs[i].fifo_empty;
      credit_in = vecs[i].credit_in; fifo_data = vecs[i].fifo_data;
      #1;
      check($sformatf("v%0d_rd", i),   {63'h0, fifo_read_en}, {63'h0, vecs[i].exp_rd});
      check($sformatf("v%0d_fv", i),   {63'h0, flit_valid},   {63'h0, vecs[i].exp_fv});
      check($sformatf("v%0d_flit", i), {30'h0, flit_out},     {30'h0, vecs[i].exp_flit});
      check($sformatf("v%0d_cr", i),   {61'h0, credits},      {61'h0, vecs[i].exp_cr});
      check($sformatf("v%0d_busy", i), {63'h0, busy},         {63'h0, vecs[i].exp_busy});
      check($sformatf("v%0d_pkt", i),  {48'h0, pkt_count},    {48'h0, vecs[i].exp_pkt});
      @(negedge clk);
    end
    credit_in = 1'b0;

    // Credit starvation: three entries, no returns
    en = 1'b1; flit_seen = 0;
    for (int i = 0; i < 3; i++) q.push_back({32'hA000_0001 + 32'(i), 32'h2000_0000 + 32'(i)});
    cycles(30);
    check("starve_flits", 64'(flit_seen),      64'd4);
    check("starve_busy",  {63'h0, busy},       64'd1);
    check("starve_fv",    {63'h0, flit_valid}, 64'd0);
    check("starve_cr",    {61'h0, credits},    64'd0);
    check("starve_pkt",   {48'h0, pkt_count},  64'd3);
    credit_in = 1'b1; cycle();
    check("ret1_cr", {61'h0, credits},    64'd1);
    check("ret1_fv", {63'h0, flit_valid}, 64'd0);
    cycle();
    check("head3_fv",   {63'h0, flit_valid}, 64'd1);
    check("head3_flit", {30'h0, flit_out},   {30'h0, FLIT_HEAD, 32'h2000_0002});
    check("head3_cr",   {61'h0, credits},    64'd0);

    // Credit return coinciding with the TAIL send at credits==1
    credit_in = 1'b1; cycle();
    check("tail3_wait_cr", {61'h0, credits}, 64'd1);
    credit_in = 1'b1; cycle();
    check("tail3_fv",   {63'h0, flit_valid}, 64'd1);
    check("tail3_flit", {30'h0, flit_out},   {30'h0, FLIT_TAIL, 32'hA000_0003});
    check("simul_cr",   {61'h0, credits},    64'd1);
    check("tail3_pkt",  {48'h0, pkt_count},  64'd4);
    q.push_back({32'h5555_AAAA, 32'h3000_0010});
    cycles(3);
    check("head4_flit", {30'h0, flit_out}, {30'h0, FLIT_HEAD, 32'h3000_0010});
    check("head4_cr",   {61'h0, credits},  64'd0);
    credit_in = 1'b1; cycle();
    cycle();
    check("tail4_flit", {30'h0, flit_out}, {30'h0, FLIT_TAIL, 32'h5555_AAAA});

    // Credit overflow
    for (int i = 0; i < 4; i++) begin
      credit_in = 1'b1; cycle();
    end
    check("full_cr",  {61'h0, credits},    64'd4);
    check("full_err", {63'h0, credit_err}, 64'd0);
    credit_in = 1'b1; cycle();
    check("ovf_err", {63'h0, credit_err}, 64'd1);
    check("ovf_cr",  {61'h0, credits},    64'd4);
    cycles(3);
    check("ovf_sticky", {63'h0, credit_err}, 64'd1);

    // en dropped while in HEAD
    rd_seen = 0; flit_seen = 0;
    q.push_back({32'hCAFE_0005, 32'h4000_0005});
    q.push_back({32'hCAFE_0006, 32'h4000_0006});
    cycles(2);
    en = 1'b0;
    cycles(8);
    check("endrop_flits", 64'(flit_seen), 64'd2);
    check("endrop_rd",    64'(rd_seen),   64'd1);
    check("endrop_last",  {30'h0, last_flit}, {30'h0, FLIT_TAIL, 32'hCAFE_0005});
    check("endrop_busy",  {63'h0, busy},  64'd0);
    en = 1'b1;
    cycles(8);
    check("resume_rd",    64'(rd_seen),   64'd2);
    check("resume_flits", 64'(flit_seen), 64'd4);
    check("resume_last",  {30'h0, last_flit}, {30'h0, FLIT_TAIL, 32'hCAFE_0006});

    // Asynchronous reset while in TAIL
    for (int i = 0; i < 4; i++) begin
      credit_in = 1'b1; cycle();
    end
    q.push_back({32'h7777_0007, 32'h5000_0007});
    cycles(3);
    check("pre_rst_fv", {63'h0, flit_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_fv",   {63'h0, flit_valid}, 64'd0);
    check("arst_flit", {30'h0, flit_out},   64'd0);
    check("arst_cr",   {61'h0, credits},    64'd4);
    check("arst_busy", {63'h0, busy},       64'd0);
    check("arst_err",  {63'h0, credit_err}, 64'd0);
    check("arst_pkt",  {48'h0, pkt_count},  64'd0);
    @(negedge clk);
    reset = 1'b0;

    // pkt_count wrap
    force dut.pkt_count_r = 16'hFFFF;
    cycle();
    release dut.pkt_count_r;
    cycle();
    check("preload_pkt", {48'h0, pkt_count}, 64'hFFFF);
    q.push_back({32'h8888_0008, 32'h6000_0008});
    cycles(4);
    check("wrap_flit", {30'h0, flit_out},  {30'h0, FLIT_TAIL, 32'h8888_0008});
    check("wrap_pkt",  {48'h0, pkt_count}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ni_tx_scheduler.md
Name: ni_tx_scheduler

Overview:
Drains the core-to-NoC write FIFO of the network interface and serialises each 64-bit {data, addr} entry into a two-flit packet (HEAD carries addr, TAIL carries data) on the NoC injection link. Link flow control is credit-based: one credit per flit buffer slot in the downstream router. The block sits between the FIFO's read side and the router's local input port. It owns the FIFO read enable and the link credit counter.

Parameters:
CREDITS, 4, downstream input-buffer depth in flits; initial and maximum credit count
CW, 3, credit counter width; must satisfy 2^CW > CREDITS

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  scheduler enable; when 0, no new packet is started
fifo_empty  in  1  FIFO empty flag
fifo_data  in  64  FIFO read data, {data[63:32], addr[31:0]}; valid the cycle after fifo_read_en
fifo_read_en  out  1  single-cycle FIFO pop strobe
flit_out  out  34  {type[1:0], payload[31:0]}; type 01=HEAD, 10=TAIL, 00=idle
flit_valid  out  1  flit_out valid this cycle; each valid flit consumes one credit
credit_in  in  1  one-cycle pulse per freed downstream slot
credits  out  CW  current credit count
busy  out  1  high in any state other than IDLE
pkt_count  out  16  number of completed packets; wraps at 16'hFFFF to 0
credit_err  out  1  sticky; set by a credit return while credits==CREDITS

Behaviour:
- Reset (async assert, synchronous-to-clk deassert is the system's job): state=IDLE, fifo_read_en=0, flit_valid=0, flit_out=0, credits=CREDITS, pkt_count=0, credit_err=0, busy=0.
- FSM states: IDLE, POP, HEAD, TAIL.
- IDLE: if en && !fifo_empty, assert fifo_read_en for one cycle and go to POP. Otherwise stay.
- POP: capture fifo_data into internal 64-bit holding register; go to HEAD. fifo_read_en=0.
- HEAD: if credits>0, drive flit_valid=1 with flit_out={2'b01, addr} and go to TAIL. Else hold with flit_valid=0 and wait.
- TAIL: if credits>0, drive flit_valid=1 with flit_out={2'b10, data}, increment pkt_count, and go to IDLE. Else wait.
- flit_valid and flit_out are registered outputs: asserted in the cycle following the state decision, and held for exactly one cycle per flit. The credit check uses the registered credit count, so a credit returning in the same cycle does not enable the send until the next cycle.
- Minimum packet issue: 4 cycles per entry (IDLE→POP→HEAD→TAIL). Back-to-back packets with no gaps beyond that.
- Credit counter: next = credits − send + credit_in.
  - Simultaneous send and return: unchanged.
  - Never underflows: a send requires credits>0.
  - Return at credits==CREDITS: count stays at CREDITS and credit_err sets. credit_err clears only on reset.
- en deassert: takes effect only in IDLE. A packet already popped always completes both flits, so no half packets appear on the link.
- fifo_empty is sampled only in IDLE. fifo_read_en is never asserted while fifo_empty=1.
- pkt_count increments on TAIL issue and wraps modulo 2^16.
- Reset mid-packet: the held entry is lost, the link returns to idle, and credits return to CREDITS. The downstream router is reset together with this block.

Decomposition:
- Shared package ni_pkg:
  - flit type constants FLIT_IDLE=2'b00, FLIT_HEAD=2'b01, FLIT_TAIL=2'b10
  - FLIT_W=34, ENTRY_W=64
  - field offsets DATA_MSB=63, ADDR_MSB=31
  - FSM state encoding
- One natural sub-module: ni_credit_counter (saturating up/down counter with overflow-error flag), reusable by the receive-side controller.

Test Plan:
- Single entry: addr=32'h1000_0004, data=32'hDEAD_BEEF, CREDITS=4, en=1 → fifo_read_en for 1 cycle, then HEAD {01,1000_0004} then TAIL {10,DEADBEEF}. credits reach 2, pkt_count=1.
- Credit starvation: 3 entries queued, no credit_in → exactly 4 flits (HEAD/TAIL, HEAD/TAIL) then stall with busy=1 in HEAD. One credit_in pulse → third HEAD issues one cycle later.
- Simultaneous credit_in and flit send at credits=1 → credits stays 1 and the next flit issues.
- Extra credit_in at credits=4 → credit_err=1 and credits=4. credit_err stays set until reset.
- en dropped during HEAD → TAIL still issues, then no further fifo_read_en while FIFO is non-empty. Re-raising en resumes issue.
- Async reset asserted in TAIL state → outputs zero immediately without a clock edge, credits=4. pkt_count wrap check: preload 16'hFFFF, complete a packet → 0.
